// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: sequential shift-add multiplier with signed/unsigned mode.
// Multiplies the operand magnitudes one bit per cycle, then applies the sign in a single fix-up cycle.
module seq_shift_add_mul #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [N:0]     acc_q, acc_d;
    logic [N-1:0]   ma_q, ma_d;
    logic [N-1:0]   mb_q, mb_d;
    logic           neg_q, neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic [N:0]     sum;
    logic [2*N-1:0] raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        sum       = acc_q + ({(N+1){mb_q[0]}} & {1'b0, ma_q});
        raw       = {acc_q[N-1:0], mb_q};
        case (state_q)
            IDLE: if (start) begin
                state_d = CALC;
                neg_d   = signed_mode & (multiplicand[N-1] ^ multiplier[N-1]);
                // N-bit negation maps -2^(N-1) onto its own unsigned magnitude
                ma_d    = (signed_mode & multiplicand[N-1]) ? -multiplicand : multiplicand;
                mb_d    = (signed_mode & multiplier[N-1]) ? -multiplier : multiplier;
                acc_d   = '0;
                cnt_d   = '0;
            end
            CALC: begin
                acc_d = {1'b0, sum[N:1]};
                mb_d  = {sum[0], mb_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(N-1)) ? FIX : CALC;
            end
            FIX: begin
                product_d = neg_q ? -raw : raw;
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == CALC) || (state_q == FIX);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul: scoreboard bench for N=8 directed and N=16 random operations.
module tb_seq_shift_add_mul;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start8 = 1'b0, sm8 = 1'b0, start16 = 1'b0, sm16 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic ready8, busy8, done8, ready16, busy16, done16;
    logic [15:0] product8;
    logic [31:0] product16;
    logic [31:0] q8[$], q16[$];
    int checks = 0, errors = 0;
    logic pd8 = 1'b0, pd16 = 1'b0;

    always #5 clk = ~clk;

    seq_shift_add_mul #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(product8)
    );

    seq_shift_add_mul #(.N(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .ready(ready16), .busy(busy16), .done(done16), .product(product16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int w, input bit s, input logic [15:0] a, input logic [15:0] b);
        longint ea, eb, p;
        if (w == 8) begin
            ea = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            eb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end else begin
            ea = s ? longint'($signed(a)) : longint'(a);
            eb = s ? longint'($signed(b)) : longint'(b);
        end
        p = ea * eb;
        return (w == 8) ? {16'h0, p[15:0]} : p[31:0];
    endfunction

    // Scoreboard monitors: pop the oldest expected product on every done pulse
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("n8_unexpected_done", 1, 0);
            else chk("n8_product", product8, q8.pop_front());
            chk("n8_done_width", pd8, 0);
        end
        pd8 = done8;
    end

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) chk("n16_unexpected_done", 1, 0);
            else chk("n16_product", product16, q16.pop_front());
            chk("n16_done_width", pd16, 0);
        end
        pd16 = done16;
    end

    // Issue one operation, then verify busy length, done timing and ready return.
    task automatic run(input int w, input bit s, input logic [15:0] a, input logic [15:0] b);
        int bcnt = 0;
        bit seen = 0;
        @(negedge clk);
        if (w == 8) begin start8 = 1; sm8 = s; a8 = a[7:0]; b8 = b[7:0]; q8.push_back(ref_mul(8, s, a, b)); end
        else begin start16 = 1; sm16 = s; a16 = a; b16 = b; q16.push_back(ref_mul(16, s, a, b)); end
        @(posedge clk);
        #1 start8 = 0; start16 = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (w == 8 ? done8 : done16) seen = 1;
            else if (w == 8 ? busy8 : busy16) bcnt++;
        end
        chk("done_seen", seen, 1);
        chk("busy_cycles", bcnt, w + 1);
        @(negedge clk);
        chk("ready_after", w == 8 ? ready8 : ready16, 1);
    endtask

    initial begin
        bit seen;
        #12;
        chk("rst_ready", ready8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_product", product8, 0);
        chk("rst16_product", product16, 0);
        rst_n = 1;
        run(8, 0, 255, 255);
        run(8, 1, 16'h80, 16'h80);
        run(8, 1, 16'hFD, 5);
        run(8, 0, 16'hFD, 5);
        run(8, 1, 0, 16'h81);
        run(8, 0, 1, 16'hFF);
        // Held start with operands changing mid-operation
        @(negedge clk);
        start8 = 1; sm8 = 0; a8 = 12; b8 = 10;
        q8.push_back(16'd120);
        q8.push_back(16'd49);
        @(posedge clk);
        #1 a8 = 7; b8 = 7;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = done8;
        end
        chk("held_first_done", seen, 1);
        @(posedge clk);
        @(posedge clk);
        #1 start8 = 0;
        chk("held_reaccepted", busy8, 1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = done8;
        end
        chk("held_second_done", seen, 1);
        // Reset in the middle of CALC abandons the operation
        @(negedge clk);
        start8 = 1; sm8 = 0; a8 = 100; b8 = 3;
        @(posedge clk);
        #1 start8 = 0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy8, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_ready", ready8, 1);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_product", product8, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (14) @(negedge clk);
        run(8, 0, 3, 4);
        for (int i = 0; i < 200; i++)
            run(16, $urandom_range(0, 1), 16'($urandom), 16'($urandom));
        run(16, 1, 16'h8000, 16'h8000);
        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
